// File: rtl/fsk_byte_deframer.sv
// Async byte deframer for the demodulated FSK bit stream.
// Start-edge validation, 3-sample mid-bit majority vote, valid/ready output.
module fsk_byte_deframer #(
    parameter int CLKS_PER_BIT = 1000,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CYC_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CYC_S1   = CW'(HALF);
    localparam logic [CW-1:0] CYC_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 v0_q, v0_d;
    logic                 v1_q, v1_d;
    logic                 sync1_q, s_in_q, s_prev_q;

    logic wrap, dec, vote, deliver;

    assign wrap = (cyc_q == CYC_LAST);
    assign dec  = (cyc_q == CYC_DEC);
    assign vote = (v0_q & v1_q) | (v0_q & s_in_q) | (v1_q & s_in_q);

    always_comb begin
        state_d   = state_q;
        cyc_d     = wrap ? '0 : cyc_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ovr_d     = 1'b0;
        v0_d      = v0_q;
        v1_d      = v1_q;
        deliver   = 1'b0;

        if (cyc_q == CYC_S0) v0_d = s_in_q;
        if (cyc_q == CYC_S1) v1_d = s_in_q;

        unique case (state_q)
            IDLE: begin
                cyc_d     = '0;
                bit_idx_d = '0;
                if (s_prev_q && !s_in_q) state_d = START;
            end
            START: begin
                if (dec && vote) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else if (wrap) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (dec) shift_d[bit_idx_q] = vote;
                if (wrap) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (dec) begin
                    cyc_d = '0;
                    if (vote) begin
                        state_d = IDLE;
                        deliver = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                        fe_d    = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                cyc_d = '0;
                if (s_in_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
            end
        endcase

        if (valid_q && byte_ready) valid_d = 1'b0;

        // A load in the accept cycle wins over the drop of byte_valid
        if (deliver) begin
            if (!valid_q || byte_ready) begin
                byte_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            s_in_q    <= 1'b1;
            s_prev_q  <= 1'b1;
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            v0_q      <= 1'b1;
            v1_q      <= 1'b1;
        end else begin
            sync1_q   <= bit_in;
            s_in_q    <= sync1_q;
            s_prev_q  <= s_in_q;
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
        end
    end

    assign byte_data   = byte_q;
    assign byte_valid  = valid_q;
    assign framing_err = fe_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fsk_byte_deframer.sv
// Directed bench for fsk_byte_deframer at 16 clk/bit, 8 data bits.
// Each scenario task drives frames and compares monitor counts inline.
module tb_fsk_byte_deframer;

    localparam int CPB = 16;
    localparam int NB  = 8;
    localparam int FRAME_CYC = CPB * (NB + 2);

    logic          clk;
    logic          rst;
    logic          bit_in;
    logic [NB-1:0] byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          framing_err;
    logic          overrun;
    logic          busy;

    int n_cmp;
    int n_bad;

    int vcyc;
    int ovr_cnt;
    int fe_cnt;
    int busy_cyc;
    int both_cnt;
    logic [NB-1:0] last_acc;

    fsk_byte_deframer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (NB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .framing_err(framing_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        vcyc     = 0;
        ovr_cnt  = 0;
        fe_cnt   = 0;
        busy_cyc = 0;
        both_cnt = 0;
        last_acc = '0;
    end

    always @(negedge clk) begin
        if (byte_valid === 1'b1) vcyc = vcyc + 1;
        if (byte_valid === 1'b1 && byte_ready === 1'b1) last_acc = byte_data;
        if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
        if (framing_err === 1'b1) fe_cnt = fe_cnt + 1;
        if (busy === 1'b1) busy_cyc = busy_cyc + 1;
        if (framing_err === 1'b1 && overrun === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic send_bits(input logic [NB-1:0] d, input logic stop,
                             input bit spike, input int ncyc);
        logic lvl;
        int b;
        for (int c = 0; c < ncyc; c++) begin
            b = c / CPB;
            if (b == 0) lvl = 1'b0;
            else if (b == NB + 1) lvl = stop;
            else lvl = d[b-1];
            if (spike && b >= 1 && b <= NB && (c % CPB) == 9) lvl = ~lvl;
            @(posedge clk);
            #1 bit_in = lvl;
        end
    endtask

    task automatic drive_level(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 bit_in = lvl;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bit_in = 1'b1;
        byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (byte_data !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_data: got %h want 00", byte_data);
        end
        n_cmp++;
        if (byte_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_valid: got %b want 0", byte_valid);
        end
        n_cmp++;
        if (framing_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_fe: got %b want 0", framing_err);
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ovr: got %b want 0", overrun);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single;
        int v0, o0, f0;
        byte_ready = 1'b1;
        v0 = vcyc; o0 = ovr_cnt; f0 = fe_cnt;
        send_bits(8'hA5, 1'b1, 1'b0, FRAME_CYC);
        drive_level(1'b1, 20);
        n_cmp++;
        if (vcyc - v0 !== 1) begin
            n_bad++;
            $display("FAIL a5_valid_cycles: got %0d want 1", vcyc - v0);
        end
        n_cmp++;
        if (last_acc !== 8'hA5) begin
            n_bad++;
            $display("FAIL a5_data: got %h want a5", last_acc);
        end
        n_cmp++;
        if (fe_cnt - f0 !== 0) begin
            n_bad++;
            $display("FAIL a5_fe: got %0d want 0", fe_cnt - f0);
        end
        n_cmp++;
        if (ovr_cnt - o0 !== 0) begin
            n_bad++;
            $display("FAIL a5_ovr: got %0d want 0", ovr_cnt - o0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL a5_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int o0, f0;
        byte_ready = 1'b0;
        o0 = ovr_cnt; f0 = fe_cnt;
        send_bits(8'h3C, 1'b1, 1'b0, FRAME_CYC);
        send_bits(8'hC3, 1'b1, 1'b0, FRAME_CYC);
        drive_level(1'b1, 20);
        n_cmp++;
        if (byte_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_valid_held: got %b want 1", byte_valid);
        end
        n_cmp++;
        if (byte_data !== 8'h3C) begin
            n_bad++;
            $display("FAIL b2b_data_held: got %h want 3c", byte_data);
        end
        n_cmp++;
        if (ovr_cnt - o0 !== 1) begin
            n_bad++;
            $display("FAIL b2b_ovr_count: got %0d want 1", ovr_cnt - o0);
        end
        n_cmp++;
        if (fe_cnt - f0 !== 0) begin
            n_bad++;
            $display("FAIL b2b_fe: got %0d want 0", fe_cnt - f0);
        end
        byte_ready = 1'b1;
        drive_level(1'b1, 3);
        n_cmp++;
        if (byte_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: got %b want 0", byte_valid);
        end
        n_cmp++;
        if (last_acc !== 8'h3C) begin
            n_bad++;
            $display("FAIL b2b_acc: got %h want 3c", last_acc);
        end
    endtask

    task automatic test_glitch;
        int v0, b0;
        v0 = vcyc; b0 = busy_cyc;
        drive_level(1'b0, 4);
        drive_level(1'b1, 40);
        n_cmp++;
        if ((busy_cyc - b0 > 0) !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_start: got %0d busy cycles want >0", busy_cyc - b0);
        end
        n_cmp++;
        if (vcyc - v0 !== 0) begin
            n_bad++;
            $display("FAIL glitch_valid: got %0d want 0", vcyc - v0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_framing;
        int v0, f0;
        v0 = vcyc; f0 = fe_cnt;
        send_bits(8'h55, 1'b0, 1'b0, FRAME_CYC);
        drive_level(1'b0, 3 * CPB);
        drive_level(1'b1, 30);
        n_cmp++;
        if (fe_cnt - f0 !== 1) begin
            n_bad++;
            $display("FAIL fe_count: got %0d want 1", fe_cnt - f0);
        end
        n_cmp++;
        if (vcyc - v0 !== 0) begin
            n_bad++;
            $display("FAIL fe_valid: got %0d want 0", vcyc - v0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fe_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++;
            $display("FAIL fe_ovr_same_cycle: got %0d want 0", both_cnt);
        end
    endtask

    task automatic test_majority;
        int v0;
        v0 = vcyc;
        send_bits(8'h0F, 1'b1, 1'b1, FRAME_CYC);
        drive_level(1'b1, 20);
        n_cmp++;
        if (vcyc - v0 !== 1) begin
            n_bad++;
            $display("FAIL vote_valid: got %0d want 1", vcyc - v0);
        end
        n_cmp++;
        if (last_acc !== 8'h0F) begin
            n_bad++;
            $display("FAIL vote_data: got %h want 0f", last_acc);
        end
    endtask

    task automatic test_reset_mid;
        logic busy_before;
        int v0;
        send_bits(8'hFF, 1'b1, 1'b0, 5 * CPB + 8);
        busy_before = busy;
        n_cmp++;
        if (busy_before !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_busy_before: got %b want 1", busy_before);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        bit_in = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (byte_data !== 8'h00) begin
            n_bad++;
            $display("FAIL rmid_data: got %h want 00", byte_data);
        end
        n_cmp++;
        if (byte_valid !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_flags: got v%b f%b o%b want 000", byte_valid, framing_err, overrun);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_busy: got %b want 0", busy);
        end
        rst = 1'b0;
        v0 = vcyc;
        drive_level(1'b1, 20);
        send_bits(8'h81, 1'b1, 1'b0, FRAME_CYC);
        drive_level(1'b1, 20);
        n_cmp++;
        if (vcyc - v0 !== 1) begin
            n_bad++;
            $display("FAIL rmid_next_valid: got %0d want 1", vcyc - v0);
        end
        n_cmp++;
        if (last_acc !== 8'h81) begin
            n_bad++;
            $display("FAIL rmid_next_data: got %h want 81", last_acc);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bit_in = 1'b1;
        byte_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_majority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
